// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out framer and its bit counter.
package piso_pkg;

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

   typedef enum logic {
      StIdle  = S_IDLE,
      StShift = S_SHIFT
   } piso_state_e;

   // Counter width for a WIDTH-bit frame; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter with synchronous clear/load and a terminal-count flag at WIDTH-1.
module bit_counter
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CntW  = cnt_width(WIDTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            en_i,
   output logic [CntW-1:0] count_o,
   output logic            tc_o
);

   localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

   logic [CntW-1:0] count_q, count_d;

   assign count_o = count_q;
   assign tc_o    = (count_q == LastIdx);

   // Holds at the terminal count; it only wraps through clr_i or load_i.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && !tc_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: one WIDTH-bit word per valid/ready accept, one bit per clock out,
// back-to-back frames with no idle bit in between.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_valid_i,
   input  logic [WIDTH-1:0] load_data_i,
   output logic             load_ready_o,
   output logic             dout_o,
   output logic             dout_valid_o,
   output logic             frame_done_o
);

   localparam int unsigned     CntW   = cnt_width(WIDTH);
   localparam logic [CntW-1:0] PenIdx = CntW'(WIDTH - 2);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             frame_done_q, frame_done_d;

   logic [CntW-1:0] count;
   logic            cnt_tc;
   logic            cnt_clr;
   logic            cnt_en;
   logic            accept;

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   bit_counter #(
      .WIDTH (WIDTH),
      .CntW  (CntW)
   ) u_bit_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (cnt_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .en_i       (cnt_en),
      .count_o    (count),
      .tc_o       (cnt_tc)
   );

   // Ready on the last bit lets the next word follow with no gap.
   assign load_ready_o = !rst_i && ((state_q == StIdle) || ((state_q == StShift) && cnt_tc));
   assign accept       = load_valid_i && load_ready_o;

   // dout_q holds the bit currently on the wire; shreg_q holds the bits still to come.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
      frame_done_d = 1'b0;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;

      if (accept) begin
         state_d      = StShift;
         shreg_d      = advance(load_data_i);
         dout_d       = head_bit(load_data_i);
         dout_valid_d = 1'b1;
         cnt_clr      = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               shreg_d = '0;
            end
            StShift: begin
               if (cnt_tc) begin
                  state_d = StIdle;
                  shreg_d = '0;
                  cnt_clr = 1'b1;
               end else begin
                  shreg_d      = advance(shreg_q);
                  dout_d       = head_bit(shreg_q);
                  dout_valid_d = 1'b1;
                  frame_done_d = (count == PenIdx);
                  cnt_en       = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               shreg_d = '0;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out framer that sits directly upstream of the sequence-detector FSM.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on dout/dout_valid. The detector's din is driven from dout.
- Supports back-to-back words with no idle bit between frames, so patterns that straddle a word boundary reach the detector intact.

Parameters:
- WIDTH, 8, bits per parallel word (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream presents a word on load_data.
- load_data  input  WIDTH  parallel word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a frame bit this cycle.
- frame_done  output  1  one-cycle pulse coinciding with the last bit of a frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values (registered outputs): state=IDLE, shift register=0, bit count=0, dout=0, dout_valid=0, frame_done=0.
- States:
  - IDLE: no frame in flight.
  - SHIFT: frame in flight; bit count runs from 0 to WIDTH-1.
- load_ready is combinational: high when state==IDLE, or when state==SHIFT and count==WIDTH-1. It is low in every other case, including during rst.
- Accept: at a rising edge with load_valid && load_ready && !rst.
  - load_data is captured into the shift register.
  - count resets to 0 and state becomes SHIFT.
- Latency: the first bit appears on dout with dout_valid=1 in the cycle immediately after the accept edge. Bits then advance one per clock, WIDTH cycles per word.
- Bit order:
  - MSB_FIRST=1: dout = shreg[WIDTH-1], shift left, zero fill.
  - MSB_FIRST=0: dout = shreg[0], shift right, zero fill.
- Last bit (count==WIDTH-1): frame_done=1 in the same cycle.
  - If a word is accepted in this cycle, the next cycle shows bit 0 of the new frame. dout_valid stays 1 with no gap.
  - Otherwise state returns to IDLE, and the next cycle has dout=0, dout_valid=0, frame_done=0.
- load_valid while load_ready=0: the word is ignored. Upstream must hold it (standard valid/ready; nothing is lost).
- load_data changing while no accept occurs: no effect.
- Reset mid-frame: the frame is discarded. The next cycle has dout_valid=0, dout=0, and load_ready=1 once rst falls. No partial bits are emitted after reset.
- Simultaneous rst and load_valid: rst wins and the word is not accepted.
- Counter width: $clog2(WIDTH). It wraps only through the reload/IDLE path and never free-runs.
- dout, dout_valid and frame_done are registered. There is no combinational path from load_* to dout*.

Decomposition:
- Shared package piso_pkg:
  - state encoding constants S_IDLE=1'b0, S_SHIFT=1'b1.
  - a function returning the counter width for a given WIDTH.
- One natural sub-module: bit_counter (parameterized up-counter with sync clear, load, and a terminal-count flag at WIDTH-1). This counter is also needed by later framing blocks.
- The shift/state logic stays in piso_serializer.

Test Plan (WIDTH=8 unless stated):
1. Reset then idle: hold rst for 2 cycles, load_valid=0 -> dout=0, dout_valid=0, frame_done=0, load_ready=1 after rst falls.
2. Single word, MSB_FIRST=1: accept 8'hA5 -> cycles 1..8 give dout=1,0,1,0,0,1,0,1 with dout_valid=1; frame_done=1 only in cycle 8; cycle 9 has dout_valid=0.
3. Back-to-back: 8'h0A, then 8'hA0 offered on the last-bit cycle -> 16 contiguous valid bits 0000101010100000, no gap, frame_done in cycles 8 and 16. The chained detector's dout asserts at the expected 1010 hits.
4. Backpressure: load_valid=1 with 8'hFF asserted in cycle 3 of a frame -> load_ready=0 until cycle 8; the word is accepted at the cycle-8 edge; the first 1 appears in cycle 9.
5. LSB-first: MSB_FIRST=0, accept 8'h01 -> dout=1,0,0,0,0,0,0,0.
6. Mid-frame reset: assert rst in cycle 4 of 8'hFF -> next cycle dout_valid=0, dout=0; no further frame bits; a new 8'h80 is accepted normally afterwards.
